// File: rtl/nn_framer_pkg.sv
// Shared types and constants for the NN stream framer: FSM states,
// settings register offsets, readback addresses and the bad-address marker.
package nn_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] REG_CTRL  = 8'd0;
  localparam logic [7:0] REG_N_IN  = 8'd1;
  localparam logic [7:0] REG_N_OUT = 8'd2;

  localparam logic [7:0] RB_STATUS = 8'd0;
  localparam logic [7:0] RB_CFG    = 8'd1;
  localparam logic [7:0] RB_STATS  = 8'd2;

  localparam logic [63:0] RB_BAD = 64'h0BADC0DE0BADC0DE;

endpackage

// File: rtl/nn_framer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output; write-to-read latency 1 cycle.
// Pushes are dropped while full; full/empty come from registered pointers, so a pop frees space next cycle.
module nn_framer_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level  = wr_ptr_q - rd_ptr_q;
  assign push   = wr_en & ~full;
  assign pop    = rd_en & ~empty;
  // Head is forced to zero when empty so nothing stale leaks onto the bus.
  assign rd_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/nn_stream_framer.sv
// Frames N_IN-word inferences into an ap_fifo core, caps inferences in flight, tlast-marks N_OUT-word results.
// Input path is combinational; output via 1-cycle FWFT FIFO; NN_FRAMER_STATS_EN adds inference/error counters.
module nn_stream_framer
  import nn_framer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int N_IN         = 16,
  parameter int N_OUT        = 5,
  parameter int OUT_DEPTH    = 32,
  parameter int MAX_INFLIGHT = 2,
  parameter int SR_BASE      = 128
) (
  input  logic              ce_clk,
  input  logic              ce_rst_n,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [7:0]        rb_addr,
  output logic [63:0]       rb_data,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] core_in_dout,
  output logic              core_in_empty_n,
  input  logic              core_in_read,
  input  logic [DATA_W-1:0] core_out_din,
  input  logic              core_out_write,
  output logic              core_out_full_n,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int LW = $clog2(OUT_DEPTH) + 1;

  state_t        state_q, state_d;
  logic          enable_q, enable_d, cfg_err_q, cfg_err_d, frame_err_q, frame_err_d;
  logic          rst_done_q;
  logic [15:0]   n_in_q, n_in_d, n_out_q, n_out_d;
  logic [15:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [7:0]    in_flight_q, in_flight_d;
  logic [63:0]   rb_data_q, rb_data_d, stats_rb;
  logic          wr_ctrl, wr_n_in, wr_n_out, clear;
  logic          active, gate, in_xfer, in_last, in_wrap, in_bad;
  logic          out_push, out_last, m_last_xfer, flight_dec;
  logic          fifo_empty, fifo_full;
  logic [DATA_W:0] fifo_head;
  logic [LW-1:0] fifo_level;
  logic          unused_set_bits;

  assign unused_set_bits = ^set_data[31:16];

  assign wr_ctrl  = set_stb && (set_addr == 8'(SR_BASE) + REG_CTRL);
  assign wr_n_in  = set_stb && (set_addr == 8'(SR_BASE) + REG_N_IN);
  assign wr_n_out = set_stb && (set_addr == 8'(SR_BASE) + REG_N_OUT);
  assign clear    = wr_ctrl & set_data[1];

  // Credit gate: a new frame may only start while fewer than MAX_INFLIGHT results are outstanding.
  assign active          = (state_q != ST_IDLE);
  assign gate            = active && !(in_cnt_q == '0 && in_flight_q == 8'(MAX_INFLIGHT));
  assign core_in_dout    = active ? s_axis_tdata : '0;
  assign core_in_empty_n = s_axis_tvalid & gate;
  assign s_axis_tready   = core_in_read & gate;
  assign in_xfer         = s_axis_tvalid & s_axis_tready;
  assign in_last         = (in_cnt_q == n_in_q - 16'd1);
  assign in_wrap         = in_xfer & in_last;
  assign in_bad          = in_xfer & s_axis_tlast & ~in_last;

  assign core_out_full_n = rst_done_q & ~fifo_full;
  assign out_push        = core_out_write & core_out_full_n;
  assign out_last        = (out_cnt_q >= n_out_q - 16'd1);
  assign m_axis_tvalid   = ~fifo_empty;
  assign m_axis_tdata    = fifo_head[DATA_W-1:0];
  assign m_axis_tlast    = fifo_head[DATA_W];
  assign m_last_xfer     = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign flight_dec      = m_last_xfer && (in_flight_q != '0);

  nn_framer_fifo #(.WIDTH(DATA_W + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk    (ce_clk),
    .rst_n  (ce_rst_n),
    .wr_en  (out_push),
    .wr_dat ({out_last, core_out_din}),
    .rd_en  (m_axis_tready),
    .rd_dat (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (fifo_level)
  );

  always_comb begin
    enable_d    = enable_q;
    n_in_d      = n_in_q;
    n_out_d     = n_out_q;
    cfg_err_d   = cfg_err_q;
    frame_err_d = frame_err_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    in_flight_d = in_flight_q;
    if (wr_ctrl) enable_d = set_data[0];
    if (wr_n_in) begin
      if (!active) begin
        if (set_data[15:0] != '0) n_in_d = set_data[15:0];
      end else cfg_err_d = 1'b1;
    end
    if (wr_n_out) begin
      if (!active) begin
        if (set_data[15:0] != '0) n_out_d = set_data[15:0];
      end else cfg_err_d = 1'b1;
    end
    if (in_xfer) in_cnt_d = (in_last || s_axis_tlast) ? '0 : in_cnt_q + 16'd1;
    if (in_bad) frame_err_d = 1'b1;
    if (in_wrap && !flight_dec) in_flight_d = in_flight_q + 8'd1;
    else if (!in_wrap && flight_dec) in_flight_d = in_flight_q - 8'd1;
    if (out_push) out_cnt_d = out_last ? '0 : out_cnt_q + 16'd1;
    if (clear) begin
      cfg_err_d   = 1'b0;
      frame_err_d = 1'b0;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      in_flight_d = '0;
    end
  end

  // Disable leaves via DRAIN whenever a frame is still partially accepted after this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable_q) state_d = ST_RUN;
      ST_RUN:   if (!enable_q) state_d = (in_cnt_d == '0) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (in_xfer && (in_last || s_axis_tlast)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef NN_FRAMER_STATS_EN
  logic [31:0] inf_cnt_q, inf_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    inf_cnt_d = inf_cnt_q + 32'(m_last_xfer);
    err_cnt_d = err_cnt_q + 32'(in_bad);
    if (clear) begin
      inf_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      inf_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      inf_cnt_q <= inf_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stats_rb = {err_cnt_q, inf_cnt_q};
`else
  assign stats_rb = RB_BAD;
`endif

  always_comb begin
    case (rb_addr)
      RB_STATUS: rb_data_d = 64'({state_q, cfg_err_q, frame_err_q, in_flight_q, 16'(fifo_level)});
      RB_CFG:    rb_data_d = 64'({n_out_q, n_in_q});
      RB_STATS:  rb_data_d = stats_rb;
      default:   rb_data_d = RB_BAD;
    endcase
  end

  assign rb_data = rb_data_q;

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rst_done_q  <= 1'b0;
      n_in_q      <= 16'(N_IN);
      n_out_q     <= 16'(N_OUT);
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= '0;
      rb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      cfg_err_q   <= cfg_err_d;
      frame_err_q <= frame_err_d;
      rst_done_q  <= 1'b1;
      n_in_q      <= n_in_d;
      n_out_q     <= n_out_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      in_flight_q <= in_flight_d;
      rb_data_q   <= rb_data_d;
    end
  end

endmodule

// File: tb/tb_nn_stream_framer.sv
// Directed bench for nn_stream_framer (OUT_DEPTH=4): framing, credit gating, bad tlast, drain, FIFO full, reset.
module tb_nn_stream_framer;

  localparam logic [7:0]  A_CTRL = 8'd128;
  localparam logic [7:0]  A_NIN  = 8'd129;
  localparam logic [7:0]  A_NOUT = 8'd130;
  localparam logic [63:0] BAD    = 64'h0BADC0DE0BADC0DE;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [7:0]  rb_addr;
  logic [63:0] rb_data;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [15:0] core_in_dout;
  logic        core_in_empty_n, core_in_read;
  logic [15:0] core_out_din;
  logic        core_out_write, core_out_full_n;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  nn_stream_framer #(
    .DATA_W(16), .N_IN(16), .N_OUT(5), .OUT_DEPTH(4), .MAX_INFLIGHT(2), .SR_BASE(128)
  ) dut (
    .ce_clk          (ce_clk),
    .ce_rst_n        (ce_rst_n),
    .set_stb         (set_stb),
    .set_addr        (set_addr),
    .set_data        (set_data),
    .rb_addr         (rb_addr),
    .rb_data         (rb_data),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .core_in_dout    (core_in_dout),
    .core_in_empty_n (core_in_empty_n),
    .core_in_read    (core_in_read),
    .core_out_din    (core_out_din),
    .core_out_write  (core_out_write),
    .core_out_full_n (core_out_full_n),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready)
  );

  always #5 ce_clk = ~ce_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ce_clk);
    #1;
  endtask

  task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    cyc();
    set_stb = 1'b0;
  endtask

  task automatic rb_check(input string tag, input logic [7:0] a, input logic [63:0] exp);
    rb_addr = a;
    cyc();
    chk(tag, rb_data, exp);
  endtask

  task automatic send_word(input logic [15:0] d, input logic last);
    int n = 0;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1; core_in_read = 1'b1;
    #1;
    while (!s_axis_tready && n < 20) begin cyc(); n++; end
    chk("in_ready", 64'(s_axis_tready), 64'd1);
    chk("in_dout", 64'(core_in_dout), 64'(d));
    cyc();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic core_write(input logic [15:0] d);
    int n = 0;
    core_out_din = d; core_out_write = 1'b1;
    #1;
    while (!core_out_full_n && n < 20) begin cyc(); n++; end
    chk("out_full_n_wr", 64'(core_out_full_n), 64'd1);
    cyc();
    core_out_write = 1'b0;
  endtask

  task automatic pop(input logic [15:0] d, input logic last);
    int n = 0;
    m_axis_tready = 1'b1;
    #1;
    while (!m_axis_tvalid && n < 20) begin cyc(); n++; end
    chk("m_valid", 64'(m_axis_tvalid), 64'd1);
    chk("m_data", 64'(m_axis_tdata), 64'(d));
    chk("m_last", 64'(m_axis_tlast), 64'(last));
    cyc();
    m_axis_tready = 1'b0;
  endtask

  task automatic probe_in_ready(input string tag, input logic exp);
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'hEEEE; core_in_read = 1'b1;
    #1;
    chk(tag, 64'(s_axis_tready), 64'(exp));
    s_axis_tvalid = 1'b0;
    #1;
  endtask

  initial begin
    ce_rst_n = 1'b0;
    set_stb = 1'b0; set_addr = '0; set_data = '0; rb_addr = '0;
    s_axis_tdata = 16'hA5A5; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; core_in_read = 1'b1;
    core_out_din = 16'h5A5A; core_out_write = 1'b1; m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge ce_clk);
    #1;
    chk("rst_in_ready", 64'(s_axis_tready), 64'd0);
    chk("rst_empty_n", 64'(core_in_empty_n), 64'd0);
    chk("rst_in_dout", 64'(core_in_dout), 64'd0);
    chk("rst_full_n", 64'(core_out_full_n), 64'd0);
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_rb", rb_data, 64'd0);
    s_axis_tvalid = 1'b0; core_out_write = 1'b0; m_axis_tready = 1'b0;
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    cyc();
    chk("rel_full_n", 64'(core_out_full_n), 64'd1);
    rb_check("rb_status_idle", 8'd0, 64'd0);
    rb_check("rb_cfg_reset", 8'd1, 64'h0000_0000_0005_0010);
    rb_check("rb_bad_addr", 8'd9, BAD);
`ifdef NN_FRAMER_STATS_EN
    rb_check("rb_stats_reset", 8'd2, 64'd0);
`else
    rb_check("rb_stats_absent", 8'd2, BAD);
`endif

    // Frame tlast: n_in=4, n_out=2
    sr_write(A_NIN, 32'd4);
    sr_write(A_NOUT, 32'd2);
    rb_check("rb_cfg_4_2", 8'd1, 64'h0000_0000_0002_0004);
    sr_write(A_CTRL, 32'h1);
    for (int i = 0; i < 8; i++) send_word(16'h1000 + 16'(i), 1'b0);
    core_out_din = 16'hC000; core_out_write = 1'b1;
    #1;
    chk("empty_no_bypass", 64'(m_axis_tvalid), 64'd0);
    cyc();
    core_out_write = 1'b0;
    chk("fwft_valid", 64'(m_axis_tvalid), 64'd1);
    for (int i = 1; i < 4; i++) core_write(16'hC000 + 16'(i));
    for (int i = 0; i < 4; i++) pop(16'hC000 + 16'(i), (i % 2) == 1);
    rb_check("rb_status_t1", 8'd0, 64'h0000_0000_0400_0000);
`ifdef NN_FRAMER_STATS_EN
    rb_check("rb_inf_cnt_2", 8'd2, 64'h0000_0000_0000_0002);
`endif

    // Credit gating with tready held low
    for (int i = 0; i < 8; i++) send_word(16'h2000 + 16'(i), 1'b0);
    probe_in_ready("gate_closed", 1'b0);
    chk("gate_empty_n", 64'(core_in_empty_n), 64'd0);
    repeat (3) cyc();
    probe_in_ready("gate_still_closed", 1'b0);
    for (int i = 0; i < 4; i++) core_write(16'hD000 + 16'(i));
    chk("fifo_full_credit", 64'(core_out_full_n), 64'd0);
    pop(16'hD000, 1'b0);
    probe_in_ready("gate_nonlast_pop", 1'b0);
    pop(16'hD001, 1'b1);
    probe_in_ready("gate_reopen", 1'b1);
    for (int i = 0; i < 4; i++) send_word(16'h3000 + 16'(i), 1'b0);
    probe_in_ready("gate_closed_again", 1'b0);
    rb_check("rb_status_credit", 8'd0, 64'h0000_0000_0402_0002);
    pop(16'hD002, 1'b0);
    pop(16'hD003, 1'b1);

    // FIFO full: pop at full frees space only next cycle
    for (int i = 0; i < 4; i++) core_write(16'hF000 + 16'(i));
    chk("full_after_4", 64'(core_out_full_n), 64'd0);
    core_out_din = 16'hF004; core_out_write = 1'b1; m_axis_tready = 1'b1;
    #1;
    chk("full_during_pop", 64'(core_out_full_n), 64'd0);
    chk("head_at_full", 64'(m_axis_tdata), 64'hF000);
    cyc();
    m_axis_tready = 1'b0;
    chk("full_n_after_pop", 64'(core_out_full_n), 64'd1);
    cyc();
    core_out_write = 1'b0;
    rb_check("rb_level_4", 8'd0, 64'h0000_0000_0401_0004);
    pop(16'hF001, 1'b1);
    pop(16'hF002, 1'b0);
    pop(16'hF003, 1'b1);
    pop(16'hF004, 1'b0);
    chk("fifo_empty_end", 64'(m_axis_tvalid), 64'd0);

    // Clear keeps enable, zeroes counters
    sr_write(A_CTRL, 32'h3);
    rb_check("rb_after_clear", 8'd0, 64'h0000_0000_0400_0000);
`ifdef NN_FRAMER_STATS_EN
    rb_check("rb_stats_clear", 8'd2, 64'd0);
`endif

    // Bad tlast on the 3rd word resyncs the frame
    send_word(16'h4000, 1'b0);
    send_word(16'h4001, 1'b0);
    send_word(16'h4002, 1'b1);
    rb_check("rb_frame_err", 8'd0, 64'h0000_0000_0500_0000);
    for (int i = 0; i < 4; i++) send_word(16'h4100 + 16'(i), 1'b0);
    rb_check("rb_resync_flight", 8'd0, 64'h0000_0000_0501_0000);
`ifdef NN_FRAMER_STATS_EN
    rb_check("rb_err_cnt_1", 8'd2, 64'h0000_0001_0000_0000);
`endif
    sr_write(A_CTRL, 32'h3);
    rb_check("rb_clear_err", 8'd0, 64'h0000_0000_0400_0000);

    // Drain: disable mid-frame
    send_word(16'h5000, 1'b0);
    send_word(16'h5001, 1'b0);
    sr_write(A_CTRL, 32'h0);
    cyc();
    rb_check("rb_drain", 8'd0, 64'h0000_0000_0800_0000);
    sr_write(A_NIN, 32'd8);
    send_word(16'h5002, 1'b0);
    send_word(16'h5003, 1'b0);
    probe_in_ready("idle_after_drain", 1'b0);
    rb_check("rb_idle_cfg_err", 8'd0, 64'h0000_0000_0201_0000);
    rb_check("rb_n_in_kept", 8'd1, 64'h0000_0000_0002_0004);

    // Reset mid-frame discards everything
    core_write(16'h7777);
    sr_write(A_CTRL, 32'h1);
    send_word(16'h6000, 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'h1234; core_in_read = 1'b1;
    #1;
    chk("pre_rst_m_valid", 64'(m_axis_tvalid), 64'd1);
    ce_rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(s_axis_tready), 64'd0);
    chk("mid_rst_empty_n", 64'(core_in_empty_n), 64'd0);
    chk("mid_rst_in_dout", 64'(core_in_dout), 64'd0);
    chk("mid_rst_full_n", 64'(core_out_full_n), 64'd0);
    chk("mid_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_m_data", 64'({m_axis_tlast, m_axis_tdata}), 64'd0);
    chk("mid_rst_rb", rb_data, 64'd0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge ce_clk);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    cyc();
    chk("post_rst_full_n", 64'(core_out_full_n), 64'd1);
    chk("post_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    rb_check("post_rst_cfg", 8'd1, 64'h0000_0000_0005_0010);
    rb_check("post_rst_bad", 8'd9, BAD);
    rb_check("post_rst_status", 8'd0, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
